// File: rtl/pipe_stage_hs_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_hs_if
// Description : Bundle of the pipeline-stage handshake, payload and control
//               signals.
//               master : drives the upstream beat, downstream ready, hold, flush
//               slave  : the stage itself (drives in_ready and the output beat)
//               Signals: hold_i, flush_i, in_valid_i/in_ready_o,
//                        inst_i/addr_i/sb_i, out_valid_o/out_ready_i,
//                        inst_o/addr_o/sb_o
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_stage_hs_if #(
    parameter int DW  = 32,
    parameter int AW  = 32,
    parameter int SBW = 4
);
    logic           hold_i;
    logic           flush_i;
    logic           in_valid_i;
    logic           in_ready_o;
    logic [DW-1:0]  inst_i;
    logic [AW-1:0]  addr_i;
    logic [SBW-1:0] sb_i;
    logic           out_valid_o;
    logic           out_ready_i;
    logic [DW-1:0]  inst_o;
    logic [AW-1:0]  addr_o;
    logic [SBW-1:0] sb_o;

    modport master (
        output hold_i, flush_i, in_valid_i, inst_i, addr_i, sb_i, out_ready_i,
        input  in_ready_o, out_valid_o, inst_o, addr_o, sb_o
    );

    modport slave (
        input  hold_i, flush_i, in_valid_i, inst_i, addr_i, sb_i, out_ready_i,
        output in_ready_o, out_valid_o, inst_o, addr_o, sb_o
    );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_hs.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_hs
// Description : Handshaked pipeline stage register carrying an instruction,
//               its address and a sideband field. Supports ctrl hold and
//               flush; an empty stage presents a NOP bubble.
//               Optional macro PIPE_STAGE_SKID_EN adds a skid register that
//               removes the combinational out_ready -> in_ready path.
//               Ports: clk, rstn (sync, active-low),
//                      bus (pipe_stage_hs_if.slave) - handshake/payload/ctrl
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_hs #(
    parameter int             DW      = 32,
    parameter int             AW      = 32,
    parameter int             SBW     = 4,
    parameter logic [DW-1:0]  NOP_VAL = DW'(32'h0000_0013)
) (
    input wire              clk,
    input wire              rstn,
    pipe_stage_hs_if.slave  bus
);

`ifdef PIPE_STAGE_SKID_EN
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FULL  = 2'd1,
        S_SKID  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FULL  = 2'd1
    } state_t;
`endif

    state_t         state_q, state_d;
    logic [DW-1:0]  inst_q,  inst_d;
    logic [AW-1:0]  addr_q,  addr_d;
    logic [SBW-1:0] sb_q,    sb_d;
`ifdef PIPE_STAGE_SKID_EN
    logic [DW-1:0]  skid_inst_q, skid_inst_d;
    logic [AW-1:0]  skid_addr_q, skid_addr_d;
    logic [SBW-1:0] skid_sb_q,   skid_sb_d;
`endif

    logic out_valid;
    logic in_ready;
    logic in_xfer;
    logic out_xfer;

    assign out_valid = (state_q != S_EMPTY);

    // Ready is held low during reset; flush always drains the offered beat.
`ifdef PIPE_STAGE_SKID_EN
    assign in_ready = rstn & ((~bus.hold_i & (state_q != S_SKID)) | bus.flush_i);
`else
    assign in_ready = rstn & ((~bus.hold_i & (~out_valid | bus.out_ready_i)) | bus.flush_i);
`endif

    assign in_xfer  = bus.in_valid_i & in_ready;
    assign out_xfer = out_valid & bus.out_ready_i;

    always_comb begin
        state_d = state_q;
        inst_d  = inst_q;
        addr_d  = addr_q;
        sb_d    = sb_q;
`ifdef PIPE_STAGE_SKID_EN
        skid_inst_d = skid_inst_q;
        skid_addr_d = skid_addr_q;
        skid_sb_d   = skid_sb_q;
`endif
        if (bus.flush_i) begin
            // Any output transfer this cycle already completed downstream;
            // everything held is simply dropped.
            state_d = S_EMPTY;
            inst_d  = NOP_VAL;
            addr_d  = '0;
            sb_d    = '0;
`ifdef PIPE_STAGE_SKID_EN
            skid_inst_d = NOP_VAL;
            skid_addr_d = '0;
            skid_sb_d   = '0;
`endif
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (in_xfer) begin
                        state_d = S_FULL;
                        inst_d  = bus.inst_i;
                        addr_d  = bus.addr_i;
                        sb_d    = bus.sb_i;
                    end
                end
                S_FULL: begin
                    if (in_xfer && out_xfer) begin
                        inst_d = bus.inst_i;
                        addr_d = bus.addr_i;
                        sb_d   = bus.sb_i;
                    end else if (out_xfer) begin
                        // Going empty: main reg becomes the NOP bubble.
                        state_d = S_EMPTY;
                        inst_d  = NOP_VAL;
                        addr_d  = '0;
                        sb_d    = '0;
`ifdef PIPE_STAGE_SKID_EN
                    end else if (in_xfer) begin
                        state_d     = S_SKID;
                        skid_inst_d = bus.inst_i;
                        skid_addr_d = bus.addr_i;
                        skid_sb_d   = bus.sb_i;
`endif
                    end
                end
`ifdef PIPE_STAGE_SKID_EN
                S_SKID: begin
                    if (out_xfer) begin
                        state_d     = S_FULL;
                        inst_d      = skid_inst_q;
                        addr_d      = skid_addr_q;
                        sb_d        = skid_sb_q;
                        skid_inst_d = NOP_VAL;
                        skid_addr_d = '0;
                        skid_sb_d   = '0;
                    end
                end
`endif
                default: begin
                    state_d = S_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_EMPTY;
            inst_q  <= NOP_VAL;
            addr_q  <= '0;
            sb_q    <= '0;
`ifdef PIPE_STAGE_SKID_EN
            skid_inst_q <= NOP_VAL;
            skid_addr_q <= '0;
            skid_sb_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            addr_q  <= addr_d;
            sb_q    <= sb_d;
`ifdef PIPE_STAGE_SKID_EN
            skid_inst_q <= skid_inst_d;
            skid_addr_q <= skid_addr_d;
            skid_sb_q   <= skid_sb_d;
`endif
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid;
    assign bus.inst_o      = inst_q;
    assign bus.addr_o      = addr_q;
    assign bus.sb_o        = sb_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_hs.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_hs
// Description : Directed self-checking bench for pipe_stage_hs: reset,
//               streaming, backpressure, hold, flush cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_hs;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int SBW = 4;
    localparam logic [DW-1:0] NOP = 32'h0000_0013;

    logic clk;
    logic rstn;
    int   n_vec;
    int   n_miss;

    pipe_stage_hs_if #(.DW(DW), .AW(AW), .SBW(SBW)) bus ();

    pipe_stage_hs #(.DW(DW), .AW(AW), .SBW(SBW), .NOP_VAL(NOP)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: rising edge, then return at the falling edge for sampling.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic offer(input logic v, input logic [DW-1:0] inst, input logic [AW-1:0] addr,
                         input logic [SBW-1:0] sb);
        bus.in_valid_i = v;
        bus.inst_i     = inst;
        bus.addr_i     = addr;
        bus.sb_i       = sb;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [DW-1:0] inst);
        chk_vec({tag, "_valid"}, 64'(bus.out_valid_o), 64'(v));
        chk_vec({tag, "_inst"},  64'(bus.inst_o), 64'(inst));
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rstn   = 1'b0;
        bus.hold_i      = 1'b0;
        bus.flush_i     = 1'b0;
        bus.out_ready_i = 1'b1;
        offer(1'b1, 32'hDEAD, 32'h40, 4'h1);

        // ---------------- reset ----------------
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            step();
            chk_out("rst", 1'b0, NOP);
            chk_vec("rst_addr",  64'(bus.addr_o), 64'h0);
            chk_vec("rst_sb",    64'(bus.sb_o), 64'h0);
            chk_vec("rst_ready", 64'(bus.in_ready_o), 64'h0);
        end
        rstn = 1'b1;
        offer(1'b0, '0, '0, '0);
        #1;
        chk_vec("rel_ready", 64'(bus.in_ready_o), 64'h1);

        // ---------------- streaming ----------------
        for (int i = 0; i < 8; i++) begin
            offer(1'b1, 32'hA0 + 32'(i), 32'h100 + 32'(4 * i), 4'(i));
            step();
            chk_out("strm", 1'b1, 32'hA0 + 32'(i));
            chk_vec("strm_addr", 64'(bus.addr_o), 64'(32'h100 + 32'(4 * i)));
            chk_vec("strm_sb",   64'(bus.sb_o), 64'(i));
        end
        offer(1'b0, '0, '0, '0);
        step();
        chk_out("strm_end", 1'b0, NOP);
        chk_vec("strm_end_addr", 64'(bus.addr_o), 64'h0);

        // ---------------- backpressure ----------------
        offer(1'b1, 32'hB0, 32'h200, 4'h0);
        step();
        chk_out("bp_b0", 1'b1, 32'hB0);
        bus.out_ready_i = 1'b0;
        offer(1'b1, 32'hB1, 32'h204, 4'h0);
`ifdef PIPE_STAGE_SKID_EN
        #1;
        chk_vec("bp_rdy_skid_free", 64'(bus.in_ready_o), 64'h1);
        step();
        offer(1'b1, 32'hB2, 32'h208, 4'h0);
        #1;
        chk_out("bp_hold_b0", 1'b1, 32'hB0);
        chk_vec("bp_rdy_skid_full", 64'(bus.in_ready_o), 64'h0);
        step();
        chk_out("bp_still_b0", 1'b1, 32'hB0);
        bus.out_ready_i = 1'b1;
        #1;
        chk_vec("bp_rdy_no_path", 64'(bus.in_ready_o), 64'h0);
        step();
        chk_out("bp_b1", 1'b1, 32'hB1);
        step();
        chk_out("bp_b2", 1'b1, 32'hB2);
`else
        #1;
        chk_vec("bp_rdy_blocked", 64'(bus.in_ready_o), 64'h0);
        step();
        chk_out("bp_hold_b0", 1'b1, 32'hB0);
        bus.out_ready_i = 1'b1;
        #1;
        chk_vec("bp_rdy_pass", 64'(bus.in_ready_o), 64'h1);
        step();
        chk_out("bp_b1", 1'b1, 32'hB1);
        offer(1'b1, 32'hB2, 32'h208, 4'h0);
        step();
        chk_out("bp_b2", 1'b1, 32'hB2);
`endif
        offer(1'b0, '0, '0, '0);
        step();
        chk_out("bp_end", 1'b0, NOP);

        // ---------------- hold ----------------
        offer(1'b1, 32'hC0, 32'h300, 4'h2);
        step();
        bus.out_ready_i = 1'b0;
        bus.hold_i      = 1'b1;
        offer(1'b1, 32'hC1, 32'h304, 4'h3);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_vec("hold_rdy", 64'(bus.in_ready_o), 64'h0);
            chk_out("hold_c0", 1'b1, 32'hC0);
            step();
        end
        chk_out("hold_after", 1'b1, 32'hC0);
        bus.hold_i      = 1'b0;
        bus.out_ready_i = 1'b1;
        step();
        chk_out("hold_c1", 1'b1, 32'hC1);
        chk_vec("hold_c1_sb", 64'(bus.sb_o), 64'h3);
        offer(1'b0, '0, '0, '0);
        step();
        chk_out("hold_end", 1'b0, NOP);

        // ---------------- flush with simultaneous input ----------------
        offer(1'b1, 32'hD0, 32'h400, 4'h4);
        step();
        bus.out_ready_i = 1'b0;
        offer(1'b1, 32'hD1, 32'h404, 4'h5);
        bus.flush_i = 1'b1;
        #1;
        chk_vec("fl_rdy", 64'(bus.in_ready_o), 64'h1);
        step();
        bus.flush_i = 1'b0;
        offer(1'b0, '0, '0, '0);
        chk_out("fl_empty", 1'b0, NOP);
        chk_vec("fl_addr", 64'(bus.addr_o), 64'h0);
        chk_vec("fl_sb",   64'(bus.sb_o), 64'h0);
        step();
        chk_out("fl_no_d1", 1'b0, NOP);

        // ---------------- flush + hold + output transfer ----------------
        bus.out_ready_i = 1'b1;
        offer(1'b1, 32'hE0, 32'h500, 4'h6);
        step();
        offer(1'b0, '0, '0, '0);
        bus.flush_i = 1'b1;
        bus.hold_i  = 1'b1;
        #1;
        chk_out("flh_e0", 1'b1, 32'hE0);
        chk_vec("flh_rdy", 64'(bus.in_ready_o), 64'h1);
        step();
        bus.flush_i = 1'b0;
        bus.hold_i  = 1'b0;
        chk_out("flh_empty", 1'b0, NOP);

        // ---------------- reset mid-operation ----------------
        offer(1'b1, 32'hF0, 32'h600, 4'h7);
        step();
        chk_out("mrst_f0", 1'b1, 32'hF0);
        rstn = 1'b0;
        offer(1'b1, 32'hF1, 32'h604, 4'h7);
        step();
        chk_out("mrst", 1'b0, NOP);
        chk_vec("mrst_addr", 64'(bus.addr_o), 64'h0);
        chk_vec("mrst_rdy",  64'(bus.in_ready_o), 64'h0);
        rstn = 1'b1;
        offer(1'b0, '0, '0, '0);
        step();
        chk_out("mrst_after", 1'b0, NOP);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
